regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-006 SHALL have ports: clk  in  1  sole clock; rising-edge.
REQ-007 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: wr_en  in  NWR  per-port write enable.
REQ-009 SHALL have ports: wr_addr  in  NWR x AW  write register index.
REQ-010 SHALL have ports: wr_data  in  NWR x XLEN  write data.
REQ-011 SHALL have ports: rd_addr  in  NRD x AW  read register index.
REQ-012 SHALL have ports: rd_data  out  NRD x XLEN  read data.
REQ-013 SHALL have ports: rd_busy  out  NRD  read register has a pending producer.
REQ-014 SHALL have ports: iss_en  in  1  instruction issue; marks iss_rd busy.
REQ-015 SHALL have ports: iss_rd  in  AW  destination of issued instruction.
REQ-016 SHALL have ports: flush  in  1  clears all busy bits.
REQ-017 SHALL have ports: busy_cnt  out  AW+1  number of busy registers.

Function
REQ-018 Register 0 SHALL read as zero always; writes and issues to index 0 SHALL be ignored.
REQ-019 Writes SHALL commit at the rising clk edge; read ports SHALL be combinational (zero latency).
REQ-020 Multiple write ports targeting the same register in one cycle: highest-index port SHALL win.
REQ-021 BYPASS=1: a read of a register being written this cycle SHALL return the winning wr_data; BYPASS=0: SHALL return the stored value.
REQ-022 Busy bit SHALL clear at the edge of any enabled write to that register.
REQ-023 Busy bit SHALL set at the edge when iss_en=1 for iss_rd (nonzero).
REQ-024 Same-cycle issue and write to the same register: set SHALL win (newer producer).
REQ-025 flush=1 SHALL clear all busy bits at the edge, overriding writes; a simultaneous issue SHALL still set its bit.
REQ-026 rd_busy SHALL be the stored busy bit, forced to 0 when BYPASS=1 and the register is being written this cycle; always 0 for register 0.
REQ-027 busy_cnt SHALL be registered and equal the population count of busy bits after each edge (range 0..NREGS-1).
REQ-028 Register data and busy state SHALL be independent: a write SHALL update data whether or not busy is set.

Reset
REQ-029 rst=1 at a clk edge SHALL zero all registers, all busy bits and busy_cnt; this SHALL take priority over writes, issue and flush in the same cycle.
REQ-030 After reset, rd_data SHALL be 0 and rd_busy SHALL be 0 on every port (bypassed write data still forwarded if BYPASS=1 and wr_en asserted).

Structure
REQ-031 XLEN/NREGS defaults, the AW derivation and the read/write port bundle typedefs SHALL live in a shared package regfile_pkg.
REQ-032 Busy tracking SHALL be a sub-module rf_scoreboard (busy bits, set/clear/flush priority, busy_cnt).

Verification
REQ-033 Reset, then read all addresses -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-034 Write port0 x5=0xDEADBEEF and port1 x5=0x12345678 same cycle -> next cycle x5 reads 0x12345678; same-cycle bypass read returns 0x12345678.
REQ-035 Write x0=0xFFFFFFFF, issue x0 -> x0 reads 0, rd_busy=0, busy_cnt=0.
REQ-036 Issue x7, then x9 -> busy_cnt=2, rd_busy(x7)=1; write x7 and issue x7 same cycle -> busy stays 1, busy_cnt=2.
REQ-037 Busy x3,x4, then flush with issue x10 -> busy_cnt=1, only x10 busy.
REQ-038 Write x12=0xA5A5A5A5 with rst=1 same cycle -> x12 reads 0; BYPASS=0 build: same-cycle read of a written register returns old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing defaults and port bundle types for the register file with busy scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // One write port as seen by the register file.
    typedef struct packed {
        logic                en;
        logic [AW_DEF-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
    } wr_port_t;

    // One read port: index in, data and pending-producer flag out.
    typedef struct packed {
        logic [AW_DEF-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
        logic                busy;
    } rd_port_t;

    // Register index width; NREGS is a power of two and at least 2.
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register plus a registered population count.
// Priority at each edge: reset, then flush/clear, then issue set (newest producer wins).
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NREGS-1:0] clr_i,
    input  logic             iss_en_i,
    input  logic [AW-1:0]    iss_rd_i,
    input  logic             flush_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      busy_cnt_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    // Next busy vector: flush wipes everything (writes are irrelevant then), issue always sets.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            busy_d = busy_q & ~clr_i;
        end
        if (iss_en_i && (iss_rd_i != '0)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Count is taken from the next-state vector so it matches the busy bits after the same edge.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    // Busy bits and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file (x0 hardwired to zero) with optional write-to-read bypass
// and a per-register busy scoreboard for in-flight producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = addr_width(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_rd,
    input  logic                     flush,
    output logic [AW:0]              busy_cnt
);

    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_vec;

    // Resolve this cycle's writes per register; later ports overwrite earlier ones so the highest index wins.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            wr_val[r] = '0;
        end
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p] != '0)) begin
                wr_hit[wr_addr[p]] = 1'b1;
                wr_val[wr_addr[p]] = wr_data[p];
            end
        end
    end

    // Next register contents; x0 is never stored.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = wr_hit[r] ? wr_val[r] : regs_q[r];
        end
        regs_d[0] = '0;
    end

    // Register array with synchronous reset taking priority over any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (wr_hit),
        .iss_en_i   (iss_en),
        .iss_rd_i   (iss_rd),
        .flush_i    (flush),
        .busy_o     (busy_vec),
        .busy_cnt_o (busy_cnt)
    );

    // Combinational read ports; a bypassed write also hides the busy bit it is about to clear.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data[i] = regs_q[rd_addr[i]];
            rd_busy[i] = busy_vec[rd_addr[i]];
            if ((BYPASS != 0) && wr_hit[rd_addr[i]]) begin
                rd_data[i] = wr_val[rd_addr[i]];
                rd_busy[i] = 1'b0;
            end
            if (rd_addr[i] == '0) begin
                rd_data[i] = '0;
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing and a non-bypassing instance share all inputs;
// expected values come from a reference model and flow through a scoreboard queue.
module tb_regfile_scoreboard;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic [1:0][4:0]  rd_addr;
    logic             iss_en;
    logic [4:0]       iss_rd;
    logic             flush;

    logic [1:0][31:0] rd_data_b, rd_data_n;
    logic [1:0]       rd_busy_b, rd_busy_n;
    logic [5:0]       busy_cnt_b, busy_cnt_n;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_cnt(busy_cnt_b)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_cnt(busy_cnt_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    // Expected read data for the current inputs; ascending scan lets the highest port win.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = m_regs[a];
        if (byp) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && (wr_addr[p] == a)) v = wr_data[p];
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && (wr_addr[p] == a)) return 32'd0;
            end
        end
        return {31'd0, m_busy[a]};
    endfunction

    function automatic logic [31:0] model_cnt();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return 32'(c);
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && (wr_addr[p] != 5'd0)) begin
                    m_regs[wr_addr[p]] = wr_data[p];
                    m_busy[wr_addr[p]] = 1'b0;
                end
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end
            if (iss_en && (iss_rd != 5'd0)) m_busy[iss_rd] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst     = 1'b0;
        wr_en   = 2'b00;
        wr_addr = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_rd  = 5'd0;
        flush   = 1'b0;
    endtask

    task automatic check_reads();
        for (int p = 0; p < 2; p++) begin
            push_exp($sformatf("byp rd_data%0d x%0d", p, rd_addr[p]), exp_rd(rd_addr[p], 1'b1));
            push_exp($sformatf("byp rd_busy%0d x%0d", p, rd_addr[p]), exp_busy(rd_addr[p], 1'b1));
            push_exp($sformatf("nobyp rd_data%0d x%0d", p, rd_addr[p]), exp_rd(rd_addr[p], 1'b0));
            push_exp($sformatf("nobyp rd_busy%0d x%0d", p, rd_addr[p]), exp_busy(rd_addr[p], 1'b0));
        end
        #1;
        for (int p = 0; p < 2; p++) begin
            pop_chk(rd_data_b[p]);
            pop_chk({31'd0, rd_busy_b[p]});
            pop_chk(rd_data_n[p]);
            pop_chk({31'd0, rd_busy_n[p]});
        end
    endtask

    task automatic check_cnt(input string tag);
        push_exp({"byp ", tag}, model_cnt());
        push_exp({"nobyp ", tag}, model_cnt());
        pop_chk({26'd0, busy_cnt_b});
        pop_chk({26'd0, busy_cnt_n});
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_busy[r] = 1'b0;
        end
        idle();
        rst     = 1'b1;
        rd_addr = '0;
        tick();
        tick();
        idle();

        // Reset state on every address.
        check_cnt("busy_cnt after reset");
        check_eq("busy_cnt after reset (const)", {26'd0, busy_cnt_b}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(31 - a);
            check_reads();
            tick();
        end

        // Two ports write x5 in one cycle: port 1 wins, bypass sees it immediately.
        wr_en      = 2'b11;
        wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        wr_addr[1] = 5'd5; wr_data[1] = 32'h12345678;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
        check_reads();
        check_eq("x5 same-cycle bypass", rd_data_b[0], 32'h12345678);
        tick();
        idle();
        rd_addr[1] = 5'd5;
        check_reads();
        check_eq("x5 after write", rd_data_n[1], 32'h12345678);

        // x0 ignores writes and issues.
        wr_en      = 2'b01;
        wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
        iss_en     = 1'b1; iss_rd = 5'd0;
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
        check_reads();
        tick();
        idle();
        check_reads();
        check_cnt("busy_cnt after x0 issue");

        // Issue x7 then x9; simultaneous write+issue of x7 keeps it busy.
        iss_en = 1'b1; iss_rd = 5'd7;
        tick();
        iss_rd = 5'd9;
        tick();
        idle();
        rd_addr[0] = 5'd7; rd_addr[1] = 5'd9;
        check_reads();
        check_eq("busy_cnt x7,x9", {26'd0, busy_cnt_b}, 32'd2);
        check_eq("rd_busy x7", {31'd0, rd_busy_b[0]}, 32'd1);
        wr_en      = 2'b10;
        wr_addr[1] = 5'd7; wr_data[1] = 32'h0000_7777;
        iss_en     = 1'b1; iss_rd = 5'd7;
        check_reads();
        tick();
        idle();
        check_reads();
        check_eq("x7 busy after write+issue", {31'd0, rd_busy_n[0]}, 32'd1);
        check_eq("busy_cnt after write+issue", {26'd0, busy_cnt_n}, 32'd2);

        // A write alone clears busy.
        wr_en      = 2'b01;
        wr_addr[0] = 5'd9; wr_data[0] = 32'h0000_9999;
        tick();
        idle();
        check_cnt("busy_cnt after x9 write");
        check_reads();

        // Busy x3,x4, then flush with an issue of x10 (and a write that flush overrides).
        iss_en = 1'b1; iss_rd = 5'd3;
        tick();
        iss_rd = 5'd4;
        tick();
        idle();
        check_cnt("busy_cnt x3,x4,x7");
        flush      = 1'b1;
        iss_en     = 1'b1; iss_rd = 5'd10;
        wr_en      = 2'b01;
        wr_addr[0] = 5'd3; wr_data[0] = 32'h0000_3333;
        tick();
        idle();
        check_eq("busy_cnt after flush+issue", {26'd0, busy_cnt_b}, 32'd1);
        check_cnt("busy_cnt after flush+issue");
        for (int a = 0; a < 32; a += 2) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(a + 1);
            check_reads();
        end

        // Reset wins over a same-cycle write; bypass still forwards during that cycle.
        rst        = 1'b1;
        wr_en      = 2'b01;
        wr_addr[0] = 5'd12; wr_data[0] = 32'hA5A5A5A5;
        rd_addr[0] = 5'd12; rd_addr[1] = 5'd10;
        check_reads();
        tick();
        idle();
        check_reads();
        check_eq("x12 after write under reset", rd_data_b[0], 32'd0);
        check_cnt("busy_cnt after reset");

        // Non-bypass instance returns the stored value while a write is in flight.
        wr_en      = 2'b01;
        wr_addr[0] = 5'd12; wr_data[0] = 32'h1111_1111;
        tick();
        wr_data[0] = 32'h2222_2222;
        check_reads();
        check_eq("nobyp x12 old value", rd_data_n[0], 32'h1111_1111);
        tick();
        idle();

        // Random traffic over a small address window to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            wr_en      = 2'($urandom_range(0, 3));
            wr_addr[0] = 5'($urandom_range(0, 7));
            wr_addr[1] = 5'($urandom_range(0, 7));
            wr_data[0] = $urandom;
            wr_data[1] = $urandom;
            iss_en     = ($urandom_range(0, 1) == 1);
            iss_rd     = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            rd_addr[0] = 5'($urandom_range(0, 7));
            rd_addr[1] = 5'($urandom_range(0, 31));
            check_reads();
            tick();
            check_cnt("busy_cnt random");
        end
        idle();

        check_eq("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
